audio_i2s_tx: RTL
=================

Name: audio_i2s_tx

Overview:
- I2S transmitter clocked by the 12 MHz audio PLL output.
- Takes stereo PCM sample pairs through a valid/ready handshake and buffers one pair.
- Generates BCLK, LRCLK and serial DACDAT for the on-board audio codec (codec is slave, FPGA is master).
- Holds all codec outputs idle until the PLL reports lock; returns to idle if lock is lost.

Parameters:
- DATA_W, 16, PCM sample width per channel (two's complement, MSB first).
- SLOT_BITS, 32, BCLK periods per channel slot; must be >= DATA_W+1.
- BCLK_HALF, 2, clk cycles per BCLK half-period; must be >= 1.

Ports:
- clk  in  1  12 MHz audio clock from PLL outclk_0.
- reset_n  in  1  asynchronous active-low reset.
- pll_locked  in  1  PLL locked, asynchronous to clk.
- s_left  in  DATA_W  left sample.
- s_right  in  DATA_W  right sample.
- s_valid  in  1  sample pair valid.
- s_ready  out  1  block can accept a pair.
- bclk  out  1  codec bit clock.
- lrclk  out  1  0 = left slot, 1 = right slot.
- dacdat  out  1  serial data, changes on BCLK falling edge.
- frame_start  out  1  one-cycle pulse when a frame begins (pair consumed or zero-filled).
- underrun  out  1  one-cycle pulse when a frame starts with the buffer empty.

Behaviour:
- Reset clears everything and enters IDLE.
  - Reset values: bclk=0, lrclk=0, dacdat=0, s_ready=0, frame_start=0, underrun=0, buffer empty.
- pll_locked passes through a 2-flop synchronizer to give locked_s.
- States: IDLE, RUN.
  - IDLE -> RUN when locked_s=1.
  - RUN -> IDLE the cycle after locked_s=0.
- In IDLE: outputs hold at their reset values, s_ready=0, buffer is flushed.
- On RUN entry:
  - div=0, bit_idx=0, bclk=0, lrclk=0, dacdat=0.
  - A frame load occurs in the entry cycle: frame_start=1, plus underrun=1 if the buffer is empty.
- div counts 0..BCLK_HALF-1. When div wraps, bclk toggles.
- A 1->0 toggle of bclk is a falling event.
  - bit_idx advances mod 2*SLOT_BITS.
  - lrclk and dacdat update in the same cycle as bclk.
  - First falling event occurs 2*BCLK_HALF cycles after RUN entry.
- lrclk = (bit_idx >= SLOT_BITS).
- dacdat, with k = bit_idx mod SLOT_BITS:
  - k in 1..DATA_W: bit DATA_W-k of the latched channel sample (I2S one-bit delay, MSB at k=1).
  - Otherwise 0.
- Frame load happens when bit_idx wraps to 0, or on RUN entry.
  - The left/right shift registers load from the buffer if it is full, and the buffer becomes empty.
  - If the buffer is empty, they load zeros and underrun pulses.
  - frame_start pulses in both cases.
- Buffer handshake:
  - s_ready = RUN && !buf_full.
  - A pair is accepted on s_valid && s_ready.
- Simultaneous load and accept: the load sees the pre-cycle buffer state. If the buffer is empty, that frame is zero-filled with underrun, and the accepted pair is kept for the next frame.
- Lock loss mid-frame: the frame is abandoned and the buffered pair is discarded. No partial-frame completion.
- Reset mid-frame behaves the same as lock loss but is asynchronous.
- Frame length = 2*SLOT_BITS*2*BCLK_HALF clk cycles; 256 cycles at defaults (46.875 kHz).

Decomposition:
- Shared package audio_pkg holds:
  - DATA_W/SLOT_BITS/BCLK_HALF defaults.
  - State typedef {IDLE, RUN}.
  - The frame-length constant function.
- One sub-module, i2s_bit_timer:
  - Contains the div counter, bclk toggle and bit_idx counter.
  - Outputs: bclk, fall_evt, bit_idx, frame_wrap.
- The 2-flop synchronizer is instantiated inline.

Test Plan:
- Reset with pll_locked=1, release reset_n -> RUN entry on the 3rd clk; s_ready=1 from the cycle after RUN entry; underrun pulse and frame_start at entry; first falling event 4 cycles later.
- Lock at reset, present s_left=16'hA5C3, s_right=16'h8001 before the first wrap.
  - At the next frame_start, the buffer is consumed.
  - Left slot dacdat over k=1..16 = 1010010111000011, k=0 and k=17..31 = 0.
  - Right slot = 1000000000000001, with lrclk=1 for bit_idx 32..63.
- Hold s_valid=1 continuously -> exactly one pair accepted per 256-cycle frame; s_ready low while the buffer is full; no underrun after the first frame.
- s_valid asserted exactly in the frame_start cycle with the buffer empty -> that frame is all-zero with underrun=1; the pair is transmitted in the following frame.
- Drop pll_locked for 10 cycles mid-frame -> 2 cycles later: bclk/lrclk/dacdat=0, s_ready=0, buffer flushed. On re-lock: fresh frame with underrun=1.
- Assert reset_n=0 asynchronously between clk edges mid-frame -> all outputs 0 immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared definitions for the I2S audio transmitter: parameter defaults,
// controller state type and the frame-length helper.
package audio_pkg;

   localparam int DATA_W_DEF    = 16;
   localparam int SLOT_BITS_DEF = 32;
   localparam int BCLK_HALF_DEF = 2;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   // clk cycles per stereo frame: two slots of SLOT_BITS bit clocks each
   function automatic int frame_cycles(input int slot_bits, input int bclk_half);
      return 2 * slot_bits * 2 * bclk_half;
   endfunction

endpackage

// File: rtl/i2s_bit_timer.sv
// BCLK generator: divides clk into BCLK half-periods and counts bit
// positions across one stereo frame, advancing on each BCLK falling edge.
module i2s_bit_timer
   import audio_pkg::*;
#(
   parameter int SLOT_BITS = SLOT_BITS_DEF,
   parameter int BCLK_HALF = BCLK_HALF_DEF,
   parameter int IDX_W     = $clog2(2 * SLOT_BITS)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             en,
   output logic             bclk,
   output logic             fall_evt,
   output logic [IDX_W-1:0] bit_idx,
   output logic             frame_wrap
);

   localparam int               DIV_W    = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_HALF - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(2 * SLOT_BITS - 1);

   logic [DIV_W-1:0] div;
   logic             div_wrap;

   assign div_wrap   = en && (div == DIV_LAST);
   assign fall_evt   = div_wrap && bclk;
   assign frame_wrap = fall_evt && (bit_idx == IDX_LAST);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         div     <= '0;
         bclk    <= 1'b0;
         bit_idx <= '0;
      end else if (!en) begin
         div     <= '0;
         bclk    <= 1'b0;
         bit_idx <= '0;
      end else begin
         div <= div_wrap ? '0 : div + 1'b1;
         if (div_wrap)
            bclk <= !bclk;
         if (fall_evt)
            bit_idx <= frame_wrap ? '0 : bit_idx + 1'b1;
      end
   end

endmodule

// File: rtl/audio_i2s_tx.sv
// I2S master transmitter: one-pair input buffer, frame loader, serializer
// and lock-gated run control for the codec DAC interface.
module audio_i2s_tx
   import audio_pkg::*;
#(
   parameter int DATA_W    = DATA_W_DEF,
   parameter int SLOT_BITS = SLOT_BITS_DEF,
   parameter int BCLK_HALF = BCLK_HALF_DEF
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              pll_locked,
   input  logic [DATA_W-1:0] s_left,
   input  logic [DATA_W-1:0] s_right,
   input  logic              s_valid,
   output logic              s_ready,
   output logic              bclk,
   output logic              lrclk,
   output logic              dacdat,
   output logic              frame_start,
   output logic              underrun
);

   localparam int IDX_W = $clog2(2 * SLOT_BITS);

   state_t              state, state_nxt;
   logic                sync_q, locked_s;
   logic                run_ok, entry, load, accept;
   logic                buf_full, buf_full_nxt;
   logic [DATA_W-1:0]   buf_left, buf_right, left_sr, right_sr;
   logic                fall_evt, frame_wrap;
   logic [IDX_W-1:0]    bit_idx, idx_nxt, k_nxt;
   logic                lr_nxt, data_bit;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_q   <= 1'b0;
         locked_s <= 1'b0;
      end else begin
         sync_q   <= pll_locked;
         locked_s <= sync_q;
      end
   end

   assign run_ok = (state == RUN) && locked_s;
   assign entry  = (state == IDLE) && locked_s;
   assign accept = s_valid && s_ready;

   // NOTE: every always_comb output gets a default first so no path leaves a
   // signal unassigned, which would otherwise infer a latch.
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (locked_s) state_nxt = RUN;
         RUN:     if (!locked_s) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      load         = entry || (run_ok && frame_wrap);
      buf_full_nxt = 1'b0;
      if (run_ok)
         buf_full_nxt = load ? accept : (buf_full || accept);
   end

   i2s_bit_timer #(
      .SLOT_BITS (SLOT_BITS),
      .BCLK_HALF (BCLK_HALF),
      .IDX_W     (IDX_W)
   ) u_timer (
      .clk        (clk),
      .reset_n    (reset_n),
      .en         (run_ok),
      .bclk       (bclk),
      .fall_evt   (fall_evt),
      .bit_idx    (bit_idx),
      .frame_wrap (frame_wrap)
   );

   // Position the serial outputs will show after this falling event
   assign idx_nxt  = frame_wrap ? '0 : bit_idx + 1'b1;
   assign lr_nxt   = idx_nxt >= IDX_W'(SLOT_BITS);
   assign k_nxt    = lr_nxt ? idx_nxt - IDX_W'(SLOT_BITS) : idx_nxt;
   assign data_bit = (k_nxt != '0) && (k_nxt <= IDX_W'(DATA_W));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         buf_full    <= 1'b0;
         s_ready     <= 1'b0;
         frame_start <= 1'b0;
         underrun    <= 1'b0;
         left_sr     <= '0;
         right_sr    <= '0;
         lrclk       <= 1'b0;
         dacdat      <= 1'b0;
      end else begin
         state       <= state_nxt;
         buf_full    <= buf_full_nxt;
         // Ready only from the second RUN cycle, tracking the buffer it guards
         s_ready     <= (state == RUN) && (state_nxt == RUN) && !buf_full_nxt;
         frame_start <= load;
         underrun    <= load && !buf_full;

         if (load) begin
            left_sr  <= buf_full ? buf_left  : '0;
            right_sr <= buf_full ? buf_right : '0;
         end else if (fall_evt && data_bit) begin
            if (lr_nxt)
               right_sr <= {right_sr[DATA_W-2:0], 1'b0};
            else
               left_sr  <= {left_sr[DATA_W-2:0], 1'b0};
         end

         if (!run_ok) begin
            lrclk  <= 1'b0;
            dacdat <= 1'b0;
         end else if (fall_evt) begin
            lrclk  <= lr_nxt;
            dacdat <= data_bit && (lr_nxt ? right_sr[DATA_W-1] : left_sr[DATA_W-1]);
         end
      end
   end

   // NOTE: payload registers carry no reset; buf_full alone decides whether
   // their contents are ever used, so clearing them would buy nothing.
   always_ff @(posedge clk) begin
      if (accept) begin
         buf_left  <= s_left;
         buf_right <= s_right;
      end
   end

endmodule
